// File: rtl/fetch_pair_queue.sv
// Dual-issue fetch queue: in-order circular buffer accepting up to one instruction
// pair per cycle from fetch and presenting the two oldest entries to decode.
module fetch_pair_queue #(
   parameter int PC_WIDTH = 32,
   parameter int IWIDTH   = 32,
   parameter int DEPTH    = 8
) (
   input  logic                    d_clk,
   input  logic                    d_rst,
   input  logic                    d_i_ce,
   input  logic                    f_i_valid_1,
   input  logic                    f_i_valid_2,
   input  logic [PC_WIDTH-1:0]     f_i_pc_1,
   input  logic [PC_WIDTH-1:0]     f_i_pc_2,
   input  logic [IWIDTH-1:0]       f_i_instr_1,
   input  logic [IWIDTH-1:0]       f_i_instr_2,
   input  logic                    f_i_flush,
   output logic                    f_o_ready,
   output logic                    ds_o_valid_1,
   output logic                    ds_o_valid_2,
   output logic [PC_WIDTH-1:0]     ds_o_pc_1,
   output logic [PC_WIDTH-1:0]     ds_o_pc_2,
   output logic [IWIDTH-1:0]       ds_o_instr_1,
   output logic [IWIDTH-1:0]       ds_o_instr_2,
   input  logic                    ds_i_ready_1,
   input  logic                    ds_i_ready_2,
   output logic [$clog2(DEPTH):0]  q_o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW-1:0]       wr_ptr_1;
   logic [AW-1:0]       rd_ptr_1;
   logic [CW-1:0]       count;
   logic [CW-1:0]       count_next;
   logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
   logic [IWIDTH-1:0]   instr_mem [DEPTH];

   logic push1;
   logic push2;
   logic pop1;
   logic pop2;
   logic flush;

   // Ready depends only on the registered count, so decode backpressure never
   // reaches the fetch side combinationally.
   assign f_o_ready    = (count <= CW'(DEPTH - 2));
   assign ds_o_valid_1 = (count != '0);
   assign ds_o_valid_2 = (count >= CW'(2));
   assign q_o_count    = count;

   assign flush = d_i_ce & f_i_flush;
   assign push1 = d_i_ce & f_o_ready & f_i_valid_1;
   assign push2 = push1 & f_i_valid_2;
   assign pop1  = d_i_ce & ds_o_valid_1 & ds_i_ready_1;
   assign pop2  = pop1 & ds_o_valid_2 & ds_i_ready_2;

   // Pointer arithmetic wraps naturally because DEPTH is a power of two.
   assign wr_ptr_1 = wr_ptr + AW'(1);
   assign rd_ptr_1 = rd_ptr + AW'(1);

   assign count_next = count + CW'(push1) + CW'(push2) - CW'(pop1) - CW'(pop2);

   // NOTE: state registers use non-blocking assignments so every register samples
   // the pre-edge values of its neighbours regardless of statement order.
   always_ff @(posedge d_clk or posedge d_rst) begin
      if (d_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (d_i_ce) begin
         wr_ptr <= wr_ptr + AW'(push1) + AW'(push2);
         rd_ptr <= rd_ptr + AW'(pop1) + AW'(pop2);
         count  <= count_next;
      end
   end

   // NOTE: storage has no reset; its contents are unobservable until written
   // because the outputs are masked by the valids derived from count.
   always_ff @(posedge d_clk) begin
      if (push1 && !flush) begin
         pc_mem[wr_ptr]    <= f_i_pc_1;
         instr_mem[wr_ptr] <= f_i_instr_1;
      end
      if (push2 && !flush) begin
         pc_mem[wr_ptr_1]    <= f_i_pc_2;
         instr_mem[wr_ptr_1] <= f_i_instr_2;
      end
   end

   // NOTE: each output gets a default first so no path through the block can
   // infer a latch.
   always_comb begin
      ds_o_pc_1    = '0;
      ds_o_instr_1 = '0;
      ds_o_pc_2    = '0;
      ds_o_instr_2 = '0;
      if (ds_o_valid_1) begin
         ds_o_pc_1    = pc_mem[rd_ptr];
         ds_o_instr_1 = instr_mem[rd_ptr];
      end
      if (ds_o_valid_2) begin
         ds_o_pc_2    = pc_mem[rd_ptr_1];
         ds_o_instr_2 = instr_mem[rd_ptr_1];
      end
   end

endmodule

// File: doc/fetch_pair_queue.md
# fetch_pair_queue

Dual-issue instruction fetch queue between the instruction memory and the two decode slots (ds1, ds2) of the superscalar datapath. It accepts up to one instruction pair per cycle from the fetch side, buffers pairs in an in-order circular queue, and presents the two oldest entries to the decode slots with a per-slot valid/ready handshake. Branch redirects flush the queue. Decode can stall without losing fetched instructions.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of each PC entry.
- `IWIDTH`, 32, instruction width.
- `DEPTH`, 8, queue entries; power of two, ≥ 4.

Ports:
- `d_clk`  in  1  clock; all state updates on rising edge.
- `d_rst`  in  1  asynchronous, active-high reset.
- `d_i_ce`  in  1  clock enable; when low, all state holds, including flush.
- `f_i_valid_1`, `f_i_valid_2`  in  1 each  fetch-side valid for instruction 1 and 2.
- `f_i_pc_1`, `f_i_pc_2`  in  `PC_WIDTH` each  PC of each fetched instruction.
- `f_i_instr_1`, `f_i_instr_2`  in  `IWIDTH` each  fetched instruction words.
- `f_i_flush`  in  1  redirect; discards all queue contents.
- `f_o_ready`  out  1  queue can accept a pair; high when free entries ≥ 2.
- `ds_o_valid_1`, `ds_o_valid_2`  out  1 each  head entry and head+1 entry are valid.
- `ds_o_pc_1`, `ds_o_pc_2`  out  `PC_WIDTH` each  PCs of the head and head+1 entries.
- `ds_o_instr_1`, `ds_o_instr_2`  out  `IWIDTH` each  instructions of the head and head+1 entries.
- `ds_i_ready_1`, `ds_i_ready_2`  in  1 each  decode slot accepts.
- `q_o_count`  out  log2(DEPTH)+1  occupied entries.

## Operation
- State: `wr_ptr`, `rd_ptr` (log2(DEPTH) bits, wrap modulo DEPTH), `count`, entry storage {pc, instr}.
- Push: `push1 = d_i_ce & f_o_ready & f_i_valid_1` writes entry 1 at `wr_ptr`. `push2 = push1 & f_i_valid_2` writes entry 2 at `wr_ptr+1`. `f_i_valid_2` without `f_i_valid_1` is ignored. `wr_ptr` advances by `push1 + push2`.
- Pop (in order): `pop1 = d_i_ce & ds_o_valid_1 & ds_i_ready_1`. `pop2 = pop1 & ds_o_valid_2 & ds_i_ready_2`. Slot 2 is never consumed without slot 1. `rd_ptr` advances by `pop1 + pop2`.
- `count_next = count + push1 + push2 - pop1 - pop2`. This never exceeds DEPTH and never goes below 0.
- `f_o_ready = (DEPTH - count) >= 2`. It is computed from the current `count` only, with no combinational path from `ds_i_ready_*`.
- Outputs:
  - `ds_o_valid_1 = count >= 1`.
  - `ds_o_valid_2 = count >= 2`.
  - PC and instruction outputs read combinationally at `rd_ptr` and `rd_ptr+1`, forced to 0 (MIPS nop) when the corresponding valid is low.
- Flush: when `d_i_ce & f_i_flush`, `count`, `wr_ptr` and `rd_ptr` go to 0 and push/pop in that cycle are discarded. Flush has priority over everything except reset.
- Reset: `count = 0`, pointers = 0, storage contents don't-care. Resulting output values:
  - `ds_o_valid_*` = 0.
  - `ds_o_pc_*` and `ds_o_instr_*` = 0.
  - `f_o_ready` = 1.
  - `q_o_count` = 0.

## Timing
- Push-to-visible latency is 1 cycle: a pair written at edge N appears on the ds outputs after edge N.
- Pop takes effect at the edge. The next head is presented in the same cycle after that edge.
- Simultaneous push and pop is allowed at any count, including wrap-around of both pointers.
- Full (count = DEPTH or DEPTH-1): `f_o_ready` = 0, and fetch input is ignored even if a pop occurs that cycle.
- Empty: pop requests are ignored and the valids are 0.
- Async reset mid-operation: all outputs reach their reset values immediately, without waiting for a clock edge. They remain there until the first edge after `d_rst` deasserts.
- `d_i_ce` low: no pointer, count or storage change. Outputs remain stable.

## Test plan
- Reset: assert `d_rst` mid-run with count = 5 → immediately `ds_o_valid_1/2` = 0, instr/pc outputs = 0, `q_o_count` = 0, `f_o_ready` = 1.
- Pair push: `d_i_ce` = 1; push PC 0/4 with instr 0x20080005/0x20090003 → after the next edge, valids = 1/1, `ds_o_pc` = 0/4, instr as pushed, count = 2.
- Fill/backpressure: with `ds_i_ready_*` = 0, push 4 pairs (PC 0..28) → count = 8, `f_o_ready` = 0; a 5th pair is dropped. Then both readies high for 4 cycles → pairs out in order 0/4 … 24/28, count = 0.
- Single-slot pop and wrap: with count = 3, `ds_i_ready_1` = 1 and `ds_i_ready_2` = 0 → count = 2 and the head shifts by one entry. `ds_i_ready_2` alone → no pop. Run pointers past DEPTH and check order is preserved.
- Simultaneous push/pop at count = 6: push a pair and pop 2 in the same cycle → count stays 6, new pair lands behind existing entries.
- Flush priority: assert flush together with a valid push and both readies at count = 4 → next cycle count = 0, valids = 0, and the pushed pair is absent. With `d_i_ce` = 0, flush has no effect.
